flash_erase_ctrl: RTL and testbench
===================================

Name: flash_erase_ctrl

Overview:
Parametrised SPI NOR flash erase controller, the successor of the single-shot sector-erase sequencer. One start pulse runs WREN, then a selectable erase command (sector, subsector or bulk) at a runtime address. It then polls the status register (RDSR) until WIP clears or a poll limit expires. It sits between the system control logic and the flash pins, and reports busy, done and error to the requester.

Parameters:
CLK_DIV, 2, sys_clk cycles per SCK half-period (>=1); SCK = sys_clk/(2*CLK_DIV)
CS_SETUP, 4, cycles from cs_n falling to the first SCK falling edge (>=1)
CS_GAP, 8, minimum cs_n-high cycles between frames (>=1)
ADDR_W, 24, flash address width; must be a multiple of 8
POLL_MAX, 1000000, maximum number of RDSR frames before timeout
WREN_CMD, 8'h06, write-enable opcode
SE_CMD, 8'hD8, sector-erase opcode
SSE_CMD, 8'h20, subsector-erase opcode
BE_CMD, 8'hC7, bulk-erase opcode
RDSR_CMD, 8'h05, read-status opcode

Ports:
sys_clk  in  1  system clock; all logic on its rising edge
sys_rst  in  1  synchronous, active-high reset
start  in  1  request; accepted only in IDLE
mode  in  2  00 sector, 01 subsector, 10 bulk, 11 reserved
addr  in  ADDR_W  erase address; ignored for bulk
busy  out  1  high from the cycle after acceptance until done
done  out  1  one-cycle completion pulse
error  out  1  one-cycle pulse coincident with done on failure
miso  in  1  flash serial data out
sck  out  1  SPI clock; idles high (mode 3)
cs_n  out  1  flash chip select, active low
mosi  out  1  flash serial data in

Behaviour:
- Reset (sys_rst=1 at a clock edge): next cycle cs_n=1, sck=1, mosi=0, busy=0, done=0, error=0, FSM=IDLE, all counters 0. Applies mid-frame as well; an aborted flash command is acceptable.
- States: IDLE -> WREN -> GAP -> ERASE -> GAP -> POLL -> {GAP -> POLL | DONE} -> IDLE.
- Accept: start=1 in IDLE latches mode and addr. The next cycle has busy=1 and cs_n=0, and WREN begins.
  - start while busy is ignored; it is never queued.
  - mode=11 is not accepted: one cycle after start, done=1 and error=1, busy stays 0, and cs_n never falls.
- Frame timing:
  - cs_n low, then CS_SETUP cycles, then for each bit: sck low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - mosi updates in the same cycle sck falls, MSB first. The flash samples on the sck rise.
  - After the last rising edge, hold CLK_DIV cycles, then cs_n=1 for CS_GAP cycles (GAP state).
  - mosi=0 whenever cs_n=1.
  - Frame length = CS_SETUP + 2*CLK_DIV*nbits + CLK_DIV cycles with cs_n low. Defaults: 8-bit frame = 38 cycles.
- WREN frame: 8 bits, WREN_CMD.
- ERASE frame:
  - sector/subsector: opcode followed by ADDR_W address bits, MSB first (32 bits at default).
  - bulk: opcode only, 8 bits.
- POLL frame: 16 bits. RDSR_CMD is shifted out first, then mosi=0 for the remaining 8 bits.
  - miso is sampled on each sck rising edge of bits 8..15 into SR[7:0], MSB first.
  - At frame end: SR[0]=0 -> DONE; SR[0]=1 -> GAP, then the next POLL frame.
- Poll count: counts POLL frames. If POLL_MAX frames have completed with WIP still 1, go to DONE with error.
- DONE: one cycle with done=1, error as determined, busy=0; the FSM returns to IDLE the same cycle. start is accepted on the following cycle.
- Counters: the divider counter wraps at CLK_DIV-1. The bit counter width covers ADDR_W+8. The poll counter is wide enough for POLL_MAX and saturates.

Test Plan:
- Sector erase, addr=24'hABCDEF, mode=00, flash model returns SR=8'h00. Required response:
  - mosi bytes 06 | D8 AB CD EF | 05 00 across three cs_n-low windows of 8, 32 and 16 sck pulses.
  - cs_n high >=8 cycles between windows.
  - done=1 and error=0 once; busy high throughout.
- Bulk erase, mode=10, addr=24'h123456. Required response: erase window carries only C7 (8 sck pulses), with no address bits.
- Sector erase, model returns SR=8'h03 for 3 polls, then 8'h02. Required response: exactly 4 RDSR frames, then done=1, error=0.
- POLL_MAX=5, miso tied 1. Required response: exactly 5 RDSR frames, then done=1 and error=1 in the same cycle, busy=0.
- mode=11 start. Required response: done=1 and error=1 one cycle later, cs_n stays 1, sck stays 1; a second start pulse during an active erase has no effect on frame count.
- sys_rst asserted at bit 20 of the ERASE frame. Required response:
  - next cycle cs_n=1, sck=1, mosi=0, busy=0.
  - a new start then produces a clean WREN frame.

Source files
------------

// File: rtl/flash_erase_ctrl.sv
// flash_erase_ctrl: SPI NOR erase sequencer (mode 3).
// One start pulse sends WREN, then a sector, subsector or bulk erase command.
// RDSR is then polled until WIP clears or the poll budget runs out.
// All pin and handshake outputs come straight from registers.
module flash_erase_ctrl #(
  parameter int         CLK_DIV  = 2,
  parameter int         CS_SETUP = 4,
  parameter int         CS_GAP   = 8,
  parameter int         ADDR_W   = 24,
  parameter int         POLL_MAX = 1000000,
  parameter logic [7:0] WREN_CMD = 8'h06,
  parameter logic [7:0] SE_CMD   = 8'hD8,
  parameter logic [7:0] SSE_CMD  = 8'h20,
  parameter logic [7:0] BE_CMD   = 8'hC7,
  parameter logic [7:0] RDSR_CMD = 8'h05
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic              miso,
  output logic              sck,
  output logic              cs_n,
  output logic              mosi
);

  // One timer serves setup, half-period, hold and gap, so it is sized for the longest of them.
  localparam int TMR_MAX0 = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
  localparam int TMR_MAX  = (TMR_MAX0 > CLK_DIV) ? TMR_MAX0 : CLK_DIV;
  localparam int TMR_W    = $clog2(TMR_MAX) + 1;
  localparam int SH_W     = ADDR_W + 8;
  localparam int BIT_W    = $clog2(SH_W) + 1;
  localparam int PC_W     = $clog2(POLL_MAX + 1);

  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] DIV_LAST   = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(CS_GAP - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO   = {TMR_W{1'b0}};
  localparam logic [BIT_W-1:0] BIT_ZERO   = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0] LAST_8     = BIT_W'(7);
  localparam logic [BIT_W-1:0] LAST_16    = BIT_W'(15);
  localparam logic [BIT_W-1:0] LAST_LONG  = BIT_W'(SH_W - 1);
  localparam logic [BIT_W-1:0] SR_FIRST   = BIT_W'(8);
  localparam logic [PC_W-1:0]  POLL_LIM   = PC_W'(POLL_MAX);

  localparam logic [1:0] MODE_SE  = 2'b00;
  localparam logic [1:0] MODE_SSE = 2'b01;
  localparam logic [1:0] MODE_BE  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WREN  = 3'd1,
    ST_GAP   = 3'd2,
    ST_ERASE = 3'd3,
    ST_POLL  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP = 2'd0,
    PH_LOW   = 2'd1,
    PH_HIGH  = 2'd2,
    PH_HOLD  = 2'd3
  } phase_t;

  state_t            state_r, state_nxt;
  state_t            gap_next_r, gap_next_nxt;
  phase_t            phase_r, phase_nxt;
  logic [TMR_W-1:0]  tmr_r, tmr_nxt;
  logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_nxt;
  logic [SH_W-1:0]   shift_r, shift_nxt;
  logic [7:0]        sr_r, sr_nxt;
  logic [PC_W-1:0]   poll_cnt_r, poll_cnt_nxt;
  logic [1:0]        mode_r, mode_nxt;
  logic [ADDR_W-1:0] addr_r, addr_nxt;
  logic              sck_r, sck_nxt;
  logic              cs_n_r, cs_n_nxt;
  logic              mosi_r, mosi_nxt;
  logic              busy_r, busy_nxt;
  logic              done_r, done_nxt;
  logic              error_r, error_nxt;

  logic [BIT_W-1:0]  frame_last_s;
  logic [SH_W-1:0]   erase_load_s;
  logic [PC_W-1:0]   poll_inc_s;
  logic              timeout_s;

  assign sck   = sck_r;
  assign cs_n  = cs_n_r;
  assign mosi  = mosi_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign error = error_r;

  // Index of the last bit in the frame that is currently being shifted.
  always_comb begin
    frame_last_s = LAST_8;
    case (state_r)
      ST_WREN:  frame_last_s = LAST_8;
      ST_ERASE: frame_last_s = (mode_r == MODE_SE || mode_r == MODE_SSE) ? LAST_LONG : LAST_8;
      ST_POLL:  frame_last_s = LAST_16;
      default:  frame_last_s = LAST_8;
    endcase
  end

  // Erase frame contents. Bulk erase sends the opcode only.
  // The unreachable reserved mode maps to a harmless status read.
  always_comb begin
    erase_load_s = {RDSR_CMD, {ADDR_W{1'b0}}};
    case (mode_r)
      MODE_SE:  erase_load_s = {SE_CMD, addr_r};
      MODE_SSE: erase_load_s = {SSE_CMD, addr_r};
      MODE_BE:  erase_load_s = {BE_CMD, {ADDR_W{1'b0}}};
      default:  erase_load_s = {RDSR_CMD, {ADDR_W{1'b0}}};
    endcase
  end

  // Saturating poll-frame count and the timeout decision.
  always_comb begin
    poll_inc_s = poll_cnt_r;
    if (poll_cnt_r == POLL_LIM) begin
      poll_inc_s = poll_cnt_r;
    end else begin
      poll_inc_s = poll_cnt_r + PC_W'(1);
    end
    timeout_s = (poll_inc_s >= POLL_LIM);
  end

  // Next-state logic for the sequencer, the frame engine and the registered outputs.
  always_comb begin
    state_nxt    = state_r;
    gap_next_nxt = gap_next_r;
    phase_nxt    = phase_r;
    tmr_nxt      = tmr_r;
    bit_cnt_nxt  = bit_cnt_r;
    shift_nxt    = shift_r;
    sr_nxt       = sr_r;
    poll_cnt_nxt = poll_cnt_r;
    mode_nxt     = mode_r;
    addr_nxt     = addr_r;
    sck_nxt      = sck_r;
    cs_n_nxt     = cs_n_r;
    mosi_nxt     = mosi_r;
    busy_nxt     = busy_r;
    done_nxt     = 1'b0;
    error_nxt    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          mode_nxt     = mode;
          addr_nxt     = addr;
          poll_cnt_nxt = {PC_W{1'b0}};
          if (mode == MODE_RSV) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
            error_nxt = 1'b1;
          end else begin
            state_nxt   = ST_WREN;
            phase_nxt   = PH_SETUP;
            tmr_nxt     = TMR_ZERO;
            bit_cnt_nxt = BIT_ZERO;
            shift_nxt   = {WREN_CMD, {ADDR_W{1'b0}}};
            cs_n_nxt    = 1'b0;
            busy_nxt    = 1'b1;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_GAP: begin
        if (tmr_r == GAP_LAST) begin
          state_nxt   = gap_next_r;
          phase_nxt   = PH_SETUP;
          tmr_nxt     = TMR_ZERO;
          bit_cnt_nxt = BIT_ZERO;
          cs_n_nxt    = 1'b0;
          if (gap_next_r == ST_ERASE) begin
            shift_nxt = erase_load_s;
          end else begin
            shift_nxt = {RDSR_CMD, {ADDR_W{1'b0}}};
          end
        end else begin
          tmr_nxt = tmr_r + TMR_W'(1);
        end
      end

      ST_WREN, ST_ERASE, ST_POLL: begin
        case (phase_r)
          PH_SETUP: begin
            if (tmr_r == SETUP_LAST) begin
              phase_nxt = PH_LOW;
              tmr_nxt   = TMR_ZERO;
              sck_nxt   = 1'b0;
              mosi_nxt  = shift_r[SH_W-1];
            end else begin
              tmr_nxt = tmr_r + TMR_W'(1);
            end
          end
          PH_LOW: begin
            if (tmr_r == DIV_LAST) begin
              phase_nxt = PH_HIGH;
              tmr_nxt   = TMR_ZERO;
              sck_nxt   = 1'b1;
              // Status bits arrive on bits 8..15. Their low three index bits run 0..7, MSB first.
              if (state_r == ST_POLL && bit_cnt_r >= SR_FIRST) begin
                sr_nxt[3'd7 - bit_cnt_r[2:0]] = miso;
              end else begin
                sr_nxt = sr_r;
              end
            end else begin
              tmr_nxt = tmr_r + TMR_W'(1);
            end
          end
          PH_HIGH: begin
            if (tmr_r == DIV_LAST) begin
              tmr_nxt = TMR_ZERO;
              if (bit_cnt_r == frame_last_s) begin
                phase_nxt = PH_HOLD;
              end else begin
                phase_nxt   = PH_LOW;
                bit_cnt_nxt = bit_cnt_r + BIT_W'(1);
                shift_nxt   = {shift_r[SH_W-2:0], 1'b0};
                sck_nxt     = 1'b0;
                mosi_nxt    = shift_r[SH_W-2];
              end
            end else begin
              tmr_nxt = tmr_r + TMR_W'(1);
            end
          end
          PH_HOLD: begin
            if (tmr_r == DIV_LAST) begin
              phase_nxt = PH_SETUP;
              tmr_nxt   = TMR_ZERO;
              cs_n_nxt  = 1'b1;
              sck_nxt   = 1'b1;
              mosi_nxt  = 1'b0;
              case (state_r)
                ST_WREN: begin
                  state_nxt    = ST_GAP;
                  gap_next_nxt = ST_ERASE;
                end
                ST_ERASE: begin
                  state_nxt    = ST_GAP;
                  gap_next_nxt = ST_POLL;
                end
                ST_POLL: begin
                  poll_cnt_nxt = poll_inc_s;
                  if (!sr_r[0]) begin
                    state_nxt = ST_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                  end else if (timeout_s) begin
                    state_nxt = ST_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    error_nxt = 1'b1;
                  end else begin
                    state_nxt    = ST_GAP;
                    gap_next_nxt = ST_POLL;
                  end
                end
                default: begin
                  state_nxt = ST_IDLE;
                  busy_nxt  = 1'b0;
                end
              endcase
            end else begin
              tmr_nxt = tmr_r + TMR_W'(1);
            end
          end
          default: begin
            state_nxt = ST_IDLE;
            cs_n_nxt  = 1'b1;
            sck_nxt   = 1'b1;
            mosi_nxt  = 1'b0;
            busy_nxt  = 1'b0;
          end
        endcase
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
        cs_n_nxt  = 1'b1;
        sck_nxt   = 1'b1;
        mosi_nxt  = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset takes effect even mid-frame and releases the flash at once.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r    <= ST_IDLE;
      gap_next_r <= ST_IDLE;
      phase_r    <= PH_SETUP;
      tmr_r      <= TMR_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      shift_r    <= {SH_W{1'b0}};
      sr_r       <= 8'h00;
      poll_cnt_r <= {PC_W{1'b0}};
      mode_r     <= 2'b00;
      addr_r     <= {ADDR_W{1'b0}};
      sck_r      <= 1'b1;
      cs_n_r     <= 1'b1;
      mosi_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      gap_next_r <= gap_next_nxt;
      phase_r    <= phase_nxt;
      tmr_r      <= tmr_nxt;
      bit_cnt_r  <= bit_cnt_nxt;
      shift_r    <= shift_nxt;
      sr_r       <= sr_nxt;
      poll_cnt_r <= poll_cnt_nxt;
      mode_r     <= mode_nxt;
      addr_r     <= addr_nxt;
      sck_r      <= sck_nxt;
      cs_n_r     <= cs_n_nxt;
      mosi_r     <= mosi_nxt;
      busy_r     <= busy_nxt;
      done_r     <= done_nxt;
      error_r    <= error_nxt;
    end
  end

endmodule

// File: tb/tb_flash_erase_ctrl.sv
// Testbench for flash_erase_ctrl: directed vector table plus hand-written corner sequences.
// A small behavioural flash answers RDSR, and a pin monitor records every cs_n-low window.
module tb_flash_erase_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start   = 1'b0;
  logic [1:0]  mode    = 2'b00;
  logic [23:0] addr    = 24'h000000;
  logic        busy, done, error;
  logic        miso    = 1'b0;
  logic        sck, cs_n, mosi;

  int total = 0;
  int bad   = 0;

  flash_erase_ctrl #(.POLL_MAX(5)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .mode(mode), .addr(addr),
    .busy(busy), .done(done), .error(error), .miso(miso),
    .sck(sck), .cs_n(cs_n), .mosi(mosi)
  );

  always #5 sys_clk = ~sys_clk;

  // Pin monitor: records bits, data, length and preceding gap of each cs_n-low window.
  int          frm_n = 0;
  int          frm_bits [256];
  logic [63:0] frm_data [256];
  int          frm_len  [256];
  int          frm_gap  [256];
  int          cur_bits = 0, cur_len = 0, cur_gap = 0, gap_run = 0, idle_viol = 0;
  logic [63:0] cur_data = 64'h0;
  logic        prev_cs = 1'b1, prev_sck = 1'b1;

  always @(negedge sys_clk) begin
    if (cs_n === 1'b1) begin
      if (prev_cs === 1'b0) begin
        frm_bits[frm_n & 255] = cur_bits;
        frm_data[frm_n & 255] = cur_data;
        frm_len[frm_n & 255]  = cur_len;
        frm_gap[frm_n & 255]  = cur_gap;
        frm_n++;
      end
      gap_run++;
      if (sck !== 1'b1 || mosi !== 1'b0) idle_viol++;
    end else begin
      if (prev_cs === 1'b1) begin
        cur_bits = 0; cur_len = 0; cur_data = 64'h0; cur_gap = gap_run; gap_run = 0;
      end
      cur_len++;
      if (sck === 1'b1 && prev_sck === 1'b0) begin
        cur_bits++;
        cur_data = {cur_data[62:0], mosi};
      end
    end
    prev_cs  = cs_n;
    prev_sck = sck;
  end

  // Flash model: decodes the opcode and shifts the configured status byte out on SCK falls.
  int         cfg_busy_polls = 0;
  logic [7:0] cfg_sr_busy = 8'h00, cfg_sr_final = 8'h00;
  int         poll_base = 0;
  int         m_polls = 0, m_bits = 0;
  logic [7:0] m_op = 8'h00, srv = 8'h00;
  logic       m_prev_cs = 1'b1, m_prev_sck = 1'b1;

  always @(negedge sys_clk) begin
    if (cs_n === 1'b1) begin
      if (m_prev_cs === 1'b0 && m_op == 8'h05 && m_bits >= 16) m_polls++;
      m_bits = 0; m_op = 8'h00; miso = 1'b0;
    end else begin
      if (sck === 1'b1 && m_prev_sck === 1'b0) begin
        if (m_bits < 8) m_op = {m_op[6:0], mosi};
        m_bits++;
      end else if (sck === 1'b0 && m_prev_sck === 1'b1 && m_bits >= 8 && m_bits < 16 && m_op == 8'h05) begin
        srv  = ((m_polls - poll_base) < cfg_busy_polls) ? cfg_sr_busy : cfg_sr_final;
        miso = srv[3'(15 - m_bits)];
      end
    end
    m_prev_cs  = cs_n;
    m_prev_sck = sck;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] addr;
    int          busy_polls;
    logic [7:0]  sr_busy;
    logic [7:0]  sr_final;
    int          restart_at;
    int          exp_erase_bits;
    logic [63:0] exp_erase_data;
    int          exp_erase_len;
    int          exp_polls;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v, input int idx);
    int   fb, busy_low, extra_done, cs_low_after, pbad, gbad, k, pb;
    logic seen, err_at, busy_at;
    cfg_busy_polls = v.busy_polls;
    cfg_sr_busy    = v.sr_busy;
    cfg_sr_final   = v.sr_final;
    poll_base      = m_polls;
    pb             = m_polls;
    fb             = frm_n;
    idle_viol      = idle_viol;
    mode  = v.mode;
    addr  = v.addr;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    chk($sformatf("v%0d_accept_busy", idx), busy, 1'b1);
    chk($sformatf("v%0d_accept_csn", idx), cs_n, 1'b0);
    busy_low = 0; seen = 1'b0; err_at = 1'b0; busy_at = 1'b1;
    for (int c = 1; c < 4000 && !seen; c++) begin
      if (v.restart_at != 0 && c == v.restart_at) begin
        start = 1'b1; mode = 2'b10; addr = 24'h000000;
      end else begin
        start = 1'b0;
      end
      @(negedge sys_clk);
      if (done === 1'b1) begin
        seen = 1'b1; err_at = error; busy_at = busy;
      end else if (busy !== 1'b1) begin
        busy_low++;
      end
    end
    start = 1'b0;
    chk($sformatf("v%0d_done_seen", idx), seen, 1'b1);
    chk($sformatf("v%0d_error", idx), err_at, v.exp_err);
    chk($sformatf("v%0d_busy_at_done", idx), busy_at, 1'b0);
    chk($sformatf("v%0d_busy_gaps", idx), busy_low, 0);
    extra_done = 0; cs_low_after = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      if (done !== 1'b0) extra_done++;
      if (cs_n !== 1'b1) cs_low_after++;
    end
    chk($sformatf("v%0d_done_once", idx), extra_done, 0);
    chk($sformatf("v%0d_idle_after", idx), cs_low_after, 0);
    chk($sformatf("v%0d_frames", idx), frm_n - fb, 2 + v.exp_polls);
    chk($sformatf("v%0d_rdsr_count", idx), m_polls - pb, v.exp_polls);
    k = fb & 255;
    chk($sformatf("v%0d_wren_bits", idx), frm_bits[k], 8);
    chk($sformatf("v%0d_wren_data", idx), frm_data[k], 64'h06);
    chk($sformatf("v%0d_wren_len", idx), frm_len[k], 38);
    k = (fb + 1) & 255;
    chk($sformatf("v%0d_erase_bits", idx), frm_bits[k], v.exp_erase_bits);
    chk($sformatf("v%0d_erase_data", idx), frm_data[k], v.exp_erase_data);
    chk($sformatf("v%0d_erase_len", idx), frm_len[k], v.exp_erase_len);
    pbad = 0;
    for (int p = 0; p < v.exp_polls; p++) begin
      k = (fb + 2 + p) & 255;
      if (frm_bits[k] != 16 || frm_data[k] != 64'h0500 || frm_len[k] != 70) pbad++;
    end
    chk($sformatf("v%0d_poll_frames", idx), pbad, 0);
    gbad = 0;
    for (int f = 1; f < frm_n - fb; f++) begin
      if (frm_gap[(fb + f) & 255] < 8) gbad++;
    end
    chk($sformatf("v%0d_gaps", idx), gbad, 0);
  endtask

  initial begin
    int fb, vb, csl, hit;
    vecs[0] = '{2'b00, 24'hABCDEF, 0,  8'h00, 8'h00, 0,   32, 64'hD8ABCDEF, 134, 1, 1'b0};
    vecs[1] = '{2'b10, 24'h123456, 0,  8'h00, 8'h00, 0,   8,  64'hC7,       38,  1, 1'b0};
    vecs[2] = '{2'b00, 24'h000100, 3,  8'h03, 8'h02, 0,   32, 64'hD8000100, 134, 4, 1'b0};
    vecs[3] = '{2'b01, 24'h0F0F0F, 1,  8'h01, 8'h00, 0,   32, 64'h200F0F0F, 134, 2, 1'b0};
    vecs[4] = '{2'b00, 24'hFFFFFF, 99, 8'hFF, 8'hFF, 0,   32, 64'hD8FFFFFF, 134, 5, 1'b1};
    vecs[5] = '{2'b00, 24'h5A5A5A, 0,  8'h00, 8'h00, 150, 32, 64'hD85A5A5A, 134, 1, 1'b0};

    // Reset state
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_csn", cs_n, 1'b1);
    chk("rst_sck", sck, 1'b1);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    vb = idle_viol;
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
    end
    chk("idle_pins", idle_viol - vb, 0);

    // Reserved mode: rejected with done and error one cycle later, no frame
    fb = frm_n;
    mode = 2'b11; addr = 24'h111111; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    chk("rsv_done", done, 1'b1);
    chk("rsv_error", error, 1'b1);
    chk("rsv_busy", busy, 1'b0);
    chk("rsv_csn", cs_n, 1'b1);
    chk("rsv_sck", sck, 1'b1);
    csl = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge sys_clk);
      if (cs_n !== 1'b1 || sck !== 1'b1 || busy !== 1'b0) csl++;
    end
    chk("rsv_stays_idle", csl, 0);
    chk("rsv_no_frame", frm_n - fb, 0);

    // Reset in the middle of the erase frame
    cfg_busy_polls = 0; cfg_sr_final = 8'h00; poll_base = m_polls;
    fb = frm_n;
    mode = 2'b00; addr = 24'h3C3C3C; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 1000 && hit == 0; c++) begin
      @(negedge sys_clk);
      if (frm_n == fb + 1 && cs_n === 1'b0 && cur_bits == 20) hit = 1;
    end
    chk("midrst_reached", hit, 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("midrst_csn", cs_n, 1'b1);
    chk("midrst_sck", sck, 1'b1);
    chk("midrst_mosi", mosi, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    run_vec(vecs[0], 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
